// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for a common-anode 7-segment display, fed from a load-strobed shadow register.
// Optional build macro SEG7_LZ_BLANK_EN: blank leading-zero digits above digit 0.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned DIGITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  load,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);
    localparam int unsigned DW = 4 * DIGITS;
    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [DW-1:0]     shadow_q, shadow_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Next state: shadow capture, prescaler/digit advance, and registered output decode of the current state.
    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        nib      = 4'(shadow_q >> {idx_q, 2'b00});
        an_d     = ~(DIGITS'(1) << idx_q);
        seg_d    = hex7(nib);

        if (load) begin
            shadow_d = data;
        end

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

`ifdef SEG7_LZ_BLANK_EN
        if ((idx_q != '0) && ((shadow_q >> {idx_q, 2'b00}) == '0)) begin
            seg_d = 7'h7F;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            an_q     <= '1;
            seg_q    <= 7'h7F;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule
